// File: rtl/proc_hier_core.sv
// proc_hier_core: single-cycle 16-bit WISC-style core with an 8x16 register file.
// Define PROC_CYCLE_COUNT_EN to build the free-running cycle_count register.
module proc_hier_core #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic [15:0] dmem_rdata,
   output logic [15:0] pc,
   output logic [15:0] inst,
   output logic        reg_write,
   output logic [2:0]  write_register,
   output logic [15:0] write_data,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_address,
   output logic [15:0] mem_data,
   output logic        halt,
   output logic [31:0] cycle_count
);

   localparam logic [4:0] OP_HALT  = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b01000;
   localparam logic [4:0] OP_ST    = 5'b10000;
   localparam logic [4:0] OP_LD    = 5'b10001;
   localparam logic [4:0] OP_LBI   = 5'b11000;
   localparam logic [4:0] OP_RTYPE = 5'b11011;
   localparam logic [4:0] OP_BEQZ  = 5'b01100;
   localparam logic [4:0] OP_BNEZ  = 5'b01101;
   localparam logic [4:0] OP_J     = 5'b00100;

   logic [15:0] pc_q;
   logic [15:0] pc_next;
   logic [15:0] pc_inc;
   logic        halted_q;
   logic [15:0] regs [8];

   logic [4:0]  op;
   logic [1:0]  func;
   logic        is_halt;
   logic        is_addi;
   logic        is_st;
   logic        is_ld;
   logic        is_lbi;
   logic        is_rtype;
   logic        is_beqz;
   logic        is_bnez;
   logic        is_j;

   logic [15:0] rs_val;
   logic [15:0] rt_val;
   logic [15:0] imm5;
   logic [15:0] imm8;
   logic [15:0] imm11;
   logic [15:0] alu;
   logic        taken;
   logic        active;

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign inst      = imem_data;

   assign op   = imem_data[15:11];
   assign func = imem_data[1:0];

   assign is_halt  = (op == OP_HALT);
   assign is_addi  = (op == OP_ADDI);
   assign is_st    = (op == OP_ST);
   assign is_ld    = (op == OP_LD);
   assign is_lbi   = (op == OP_LBI);
   assign is_rtype = (op == OP_RTYPE);
   assign is_beqz  = (op == OP_BEQZ);
   assign is_bnez  = (op == OP_BNEZ);
   assign is_j     = (op == OP_J);

   assign rs_val = regs[imem_data[10:8]];
   assign rt_val = regs[imem_data[7:5]];

   assign imm5  = {{11{imem_data[4]}}, imem_data[4:0]};
   assign imm8  = {{8{imem_data[7]}}, imem_data[7:0]};
   assign imm11 = {{5{imem_data[10]}}, imem_data[10:0]};

   // Retirement is suppressed both in reset and once the core has halted
   assign active = !rst && !halted_q;

   always_comb begin
      alu = rs_val + imm5;
      unique case (1'b1)
         is_lbi: alu = imm8;
         is_rtype: begin
            unique case (func)
               2'b00: alu = rs_val + rt_val;
               2'b01: alu = rt_val - rs_val;
               2'b10: alu = rs_val ^ rt_val;
               2'b11: alu = rs_val & rt_val;
            endcase
         end
         default: alu = rs_val + imm5;
      endcase
   end

   always_comb begin
      write_register = imem_data[7:5];
      unique case (1'b1)
         is_lbi:   write_register = imem_data[10:8];
         is_rtype: write_register = imem_data[4:2];
         default:  write_register = imem_data[7:5];
      endcase
   end

   assign reg_write   = active && (is_addi || is_ld || is_lbi || is_rtype);
   assign mem_read    = active && is_ld;
   assign mem_write   = active && is_st;
   assign halt        = !rst && (halted_q || is_halt);
   assign write_data  = is_ld ? dmem_rdata : alu;
   assign mem_address = alu;
   assign mem_data    = rt_val;

   assign taken = (is_beqz && (rs_val == 16'h0000)) ||
                  (is_bnez && (rs_val != 16'h0000));
   assign pc_inc = pc_q + 16'd2;

   always_comb begin
      pc_next = pc_inc;
      unique case (1'b1)
         is_j:    pc_next = pc_inc + imm11;
         taken:   pc_next = pc_inc + imm8;
         default: pc_next = pc_inc;
      endcase
   end

   // HALT leaves pc on itself so the frozen fetch keeps re-presenting HALT
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else if (!halted_q) begin
         if (is_halt) begin
            halted_q <= 1'b1;
         end else begin
            pc_q <= pc_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= 16'h0000;
         end
      end else if (reg_write) begin
         regs[write_register] <= write_data;
      end
   end

`ifdef PROC_CYCLE_COUNT_EN
   logic [31:0] cyc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= 32'd0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
      end
   end

   assign cycle_count = cyc_q;
`else
   assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_proc_hier_core.sv
// tb_proc_hier_core: directed and random programs for proc_hier_core checked
// against an instruction-level reference model (honours PROC_CYCLE_COUNT_EN).
module tb_proc_hier_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic [15:0] dmem_rdata;
   logic [15:0] pc;
   logic [15:0] inst;
   logic        reg_write;
   logic [2:0]  write_register;
   logic [15:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_data;
   logic        halt;
   logic [31:0] cycle_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   proc_hier_core #(.RESET_PC(16'h0000)) dut (
      .clk(clk),
      .rst(rst),
      .imem_addr(imem_addr),
      .imem_data(imem_data),
      .dmem_rdata(dmem_rdata),
      .pc(pc),
      .inst(inst),
      .reg_write(reg_write),
      .write_register(write_register),
      .write_data(write_data),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_address(mem_address),
      .mem_data(mem_data),
      .halt(halt),
      .cycle_count(cycle_count)
   );

   logic [15:0] imem [256];
   logic [15:0] dmem [256];

   assign imem_data  = imem[imem_addr[8:1]];
   assign dmem_rdata = dmem[mem_address[8:1]];

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] inst;
      logic        rw;
      logic [2:0]  wr;
      logic [15:0] wd;
      logic        mr;
      logic        mw;
      logic [15:0] ma;
      logic [15:0] md;
      logic        h;
      logic [31:0] cc;
   } snap_t;

   logic [15:0] m_regs [8];
   logic [15:0] m_mem [256];
   logic [15:0] m_pc = 16'h0000;
   bit          m_halted = 1'b0;
   int unsigned m_cycles = 0;

   localparam logic [15:0] NOP = 16'h0800;
   localparam logic [15:0] HLT = 16'h0000;

   function automatic logic [15:0] lbi(int rd, int imm);
      lbi = {5'b11000, 3'(rd), 8'(imm)};
   endfunction

   function automatic logic [15:0] addi(int rd, int rs, int imm);
      addi = {5'b01000, 3'(rs), 3'(rd), 5'(imm)};
   endfunction

   function automatic logic [15:0] st(int rd, int rs, int imm);
      st = {5'b10000, 3'(rs), 3'(rd), 5'(imm)};
   endfunction

   function automatic logic [15:0] ld(int rd, int rs, int imm);
      ld = {5'b10001, 3'(rs), 3'(rd), 5'(imm)};
   endfunction

   function automatic logic [15:0] rr(int rd, int rs, int rt, int f);
      rr = {5'b11011, 3'(rs), 3'(rt), 3'(rd), 2'(f)};
   endfunction

   function automatic logic [15:0] br(bit ne, int rs, int imm);
      br = {4'b0110, ne, 3'(rs), 8'(imm)};
   endfunction

   function automatic logic [15:0] jmp(int imm);
      jmp = {5'b00100, 11'(imm)};
   endfunction

   // Don't-care fields are zeroed so both sides compare only meaningful data
   function automatic snap_t mask_snap(snap_t s);
      snap_t r = s;
      if (!r.rw) begin
         r.wr = '0;
         r.wd = '0;
      end
      if (!(r.mr || r.mw)) r.ma = '0;
      return r;
   endfunction

   function automatic snap_t observe();
      snap_t s;
      s.pc = pc;
      s.inst = inst;
      s.rw = reg_write;
      s.wr = write_register;
      s.wd = write_data;
      s.mr = mem_read;
      s.mw = mem_write;
      s.ma = mem_address;
      s.md = mem_data;
      s.h = halt;
      s.cc = cycle_count;
      return mask_snap(s);
   endfunction

   function automatic string fmt(snap_t s);
      return $sformatf("pc=%h inst=%h rw=%b wr=%0d wd=%h mr=%b mw=%b ma=%h md=%h h=%b cc=%0d",
         s.pc, s.inst, s.rw, s.wr, s.wd, s.mr, s.mw, s.ma, s.md, s.h, s.cc);
   endfunction

   function automatic snap_t predict();
      snap_t e;
      logic [15:0] w, a, b, ea;
      int s5, s8;
      w  = imem[m_pc[8:1]];
      a  = m_regs[w[10:8]];
      b  = m_regs[w[7:5]];
      s5 = int'($signed(w[4:0]));
      s8 = int'($signed(w[7:0]));
      ea = 16'(int'(a) + s5);
      e = '0;
      e.pc = m_pc;
      e.inst = w;
      e.md = b;
`ifdef PROC_CYCLE_COUNT_EN
      e.cc = m_cycles;
`endif
      if (rst) return mask_snap(e);
      if (m_halted) begin
         e.h = 1'b1;
         return mask_snap(e);
      end
      case (w[15:11])
         5'b00000: e.h = 1'b1;
         5'b01000: begin
            e.rw = 1'b1; e.wr = w[7:5]; e.wd = ea;
         end
         5'b10000: begin
            e.mw = 1'b1; e.ma = ea;
         end
         5'b10001: begin
            e.mr = 1'b1; e.ma = ea;
            e.rw = 1'b1; e.wr = w[7:5]; e.wd = m_mem[(ea / 2) % 256];
         end
         5'b11000: begin
            e.rw = 1'b1; e.wr = w[10:8]; e.wd = 16'(s8);
         end
         5'b11011: begin
            e.rw = 1'b1; e.wr = w[4:2];
            case (w[1:0])
               2'd0: e.wd = 16'(int'(a) + int'(b));
               2'd1: e.wd = 16'(int'(b) - int'(a));
               2'd2: e.wd = a ^ b;
               default: e.wd = a & b;
            endcase
         end
         default: ;
      endcase
      return mask_snap(e);
   endfunction

   task automatic model_commit();
      snap_t e;
      logic [15:0] w, a;
      int nxt;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
         m_pc = 16'h0000;
         m_halted = 1'b0;
         m_cycles = 0;
         return;
      end
      m_cycles++;
      if (m_halted) return;
      e = predict();
      w = imem[m_pc[8:1]];
      a = m_regs[w[10:8]];
      nxt = int'(m_pc) + 2;
      case (w[15:11])
         5'b00000: begin
            m_halted = 1'b1;
            nxt = int'(m_pc);
         end
         5'b01100: if (a == 0) nxt += int'($signed(w[7:0]));
         5'b01101: if (a != 0) nxt += int'($signed(w[7:0]));
         5'b00100: nxt += int'($signed(w[10:0]));
         default: ;
      endcase
      if (e.rw) m_regs[e.wr] = e.wd;
      if (e.mw) m_mem[e.ma[8:1]] = e.md;
      m_pc = 16'(nxt);
   endtask

   task automatic advance();
      logic w;
      logic [15:0] a, d;
      w = mem_write;
      a = mem_address;
      d = mem_data;
      model_commit();
      @(posedge clk);
      #1;
      if (w) dmem[a[8:1]] = d;
   endtask

   task automatic boot(input logic [15:0] prog[$]);
      rst = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = NOP;
      foreach (prog[i]) imem[i] = prog[i];
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      snap_t got, exp;
      logic [15:0] prog[$];
      prog = {lbi(1, 8'h11)};
      rst = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = NOP;
      foreach (prog[i]) imem[i] = prog[i];
      advance();
      advance();
      @(negedge clk);
      checks++;
      if ({pc, halt, reg_write, mem_read, mem_write, cycle_count} !==
          {16'h0000, 4'b0000, 32'd0}) begin
         errors++;
         $display("FAIL reset_state got pc=%h h=%b rw=%b mr=%b mw=%b cc=%0d exp pc=0000 h=0 rw=0 mr=0 mw=0 cc=0",
            pc, halt, reg_write, mem_read, mem_write, cycle_count);
      end
      exp = predict();
      got = observe();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_model got %s exp %s", fmt(got), fmt(exp));
      end
      advance();
   endtask

   task automatic test_lbi();
      snap_t got, exp;
      boot({lbi(1, 8'h85), NOP});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exp = predict();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL lbi_model[%0d] got %s exp %s", i, fmt(got), fmt(exp));
         end
         if (i == 0) begin
            checks++;
            if ({reg_write, write_register, write_data, pc} !== {1'b1, 3'd1, 16'hFF85, 16'h0000}) begin
               errors++;
               $display("FAIL lbi_write got rw=%b wr=%0d wd=%h pc=%h exp rw=1 wr=1 wd=ff85 pc=0000",
                  reg_write, write_register, write_data, pc);
            end
         end else begin
            checks++;
            if (pc !== 16'h0002) begin
               errors++;
               $display("FAIL lbi_next_pc got %h exp 0002", pc);
            end
         end
         advance();
      end
   endtask

   task automatic test_arith();
      snap_t got, exp;
      boot({lbi(1, 5), lbi(2, 3), rr(3, 1, 2, 0), rr(4, 1, 2, 1),
            rr(5, 1, 2, 2), rr(6, 1, 2, 3)});
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         exp = predict();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL arith_model[%0d] got %s exp %s", i, fmt(got), fmt(exp));
         end
         if (i == 2 || i == 3) begin
            checks++;
            if (write_data !== (i == 2 ? 16'h0008 : 16'hFFFE)) begin
               errors++;
               $display("FAIL arith_result[%0d] got %h exp %h", i, write_data,
                  (i == 2 ? 16'h0008 : 16'hFFFE));
            end
         end
         advance();
      end
   endtask

   task automatic test_mem();
      snap_t got, exp;
      dmem[0] = 16'h1234;
      m_mem[0] = 16'h1234;
      boot({lbi(1, 8'h10), ld(2, 1, -16), st(2, 1, 2), ld(5, 1, 2), NOP});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         exp = predict();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL mem_model[%0d] got %s exp %s", i, fmt(got), fmt(exp));
         end
         if (i == 2) begin
            checks++;
            if ({mem_write, mem_address, mem_data} !== {1'b1, 16'h0012, 16'h1234}) begin
               errors++;
               $display("FAIL mem_store got mw=%b ma=%h md=%h exp mw=1 ma=0012 md=1234",
                  mem_write, mem_address, mem_data);
            end
         end
         if (i == 3) begin
            checks++;
            if ({mem_read, reg_write, write_data} !== {2'b11, 16'h1234}) begin
               errors++;
               $display("FAIL mem_load got mr=%b rw=%b wd=%h exp mr=1 rw=1 wd=1234",
                  mem_read, reg_write, write_data);
            end
         end
         advance();
      end
      checks++;
      if (dmem[9] !== 16'h1234) begin
         errors++;
         $display("FAIL mem_stored_word got %h exp 1234", dmem[9]);
      end
   endtask

   task automatic test_branch();
      snap_t got, exp;
      logic [15:0] prog[$];
      logic [15:0] want;
      prog = {NOP, NOP, NOP, NOP, br(0, 1, 4), NOP, NOP, br(1, 1, 4)};
      for (int i = 0; i < 8; i++) prog.push_back(NOP);
      prog.push_back(jmp(-2));
      boot(prog);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         exp = predict();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL branch_model[%0d] got %s exp %s", i, fmt(got), fmt(exp));
         end
         if (i == 5 || i == 6 || i == 15 || i == 16) begin
            want = (i == 5) ? 16'h000E : (i == 6) ? 16'h0010 : 16'h0020;
            checks++;
            if (pc !== want) begin
               errors++;
               $display("FAIL branch_pc[%0d] got %h exp %h", i, pc, want);
            end
         end
         advance();
      end
      boot({NOP, NOP, NOP, NOP, br(1, 1, 4), NOP});
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            checks++;
            if (pc !== 16'h000A) begin
               errors++;
               $display("FAIL bnez_not_taken got %h exp 000a", pc);
            end
         end
         advance();
      end
   endtask

   task automatic test_halt();
      snap_t got, exp;
      boot({lbi(3, 7), NOP, NOP, HLT, lbi(4, 1), st(3, 0, 0)});
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         exp = predict();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL halt_model[%0d] got %s exp %s", i, fmt(got), fmt(exp));
         end
         if (i >= 3) begin
            checks++;
            if ({pc, halt, reg_write, mem_write, mem_read} !== {16'h0006, 4'b1000}) begin
               errors++;
               $display("FAIL halt_frozen[%0d] got pc=%h h=%b rw=%b mw=%b mr=%b exp pc=0006 h=1 rw=0 mw=0 mr=0",
                  i, pc, halt, reg_write, mem_write, mem_read);
            end
         end
         advance();
      end
      rst = 1'b1;
      advance();
      @(negedge clk);
      checks++;
      if ({pc, halt, cycle_count} !== {16'h0000, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL halt_reset got pc=%h h=%b cc=%0d exp pc=0000 h=0 cc=0",
            pc, halt, cycle_count);
      end
      advance();
   endtask

   task automatic test_wrap();
      snap_t got, exp;
      logic [31:0] want_cc;
      boot({lbi(1, 8'hFF), addi(1, 1, 1), NOP, NOP, NOP});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         exp = predict();
         got = observe();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL wrap_model[%0d] got %s exp %s", i, fmt(got), fmt(exp));
         end
         if (i == 1) begin
            checks++;
            if ({reg_write, write_data} !== {1'b1, 16'h0000}) begin
               errors++;
               $display("FAIL wrap_addi got rw=%b wd=%h exp rw=1 wd=0000", reg_write, write_data);
            end
         end
`ifdef PROC_CYCLE_COUNT_EN
         want_cc = 32'(i);
`else
         want_cc = 32'd0;
`endif
         checks++;
         if (cycle_count !== want_cc) begin
            errors++;
            $display("FAIL cycle_count[%0d] got %0d exp %0d", i, cycle_count, want_cc);
         end
         advance();
      end
   endtask

   function automatic logic [15:0] rand_inst();
      logic [15:0] r;
      logic [4:0] ops [10];
      ops = '{5'b00001, 5'b01000, 5'b10000, 5'b10001, 5'b11000,
              5'b11011, 5'b01100, 5'b01101, 5'b00100, 5'b10110};
      r = 16'($urandom);
      if ($urandom_range(0, 63) == 0) return HLT;
      r[15:11] = ops[$urandom_range(0, 9)];
      return r;
   endfunction

   task automatic test_random();
      snap_t got, exp;
      logic [15:0] prog[$];
      for (int run = 0; run < 3; run++) begin
         for (int i = 0; i < 256; i++) begin
            dmem[i] = 16'($urandom);
            m_mem[i] = dmem[i];
         end
         prog = {};
         for (int i = 0; i < 256; i++) prog.push_back(rand_inst());
         boot(prog);
         for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            exp = predict();
            got = observe();
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL random[%0d.%0d] got %s exp %s", run, i, fmt(got), fmt(exp));
            end
            advance();
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         dmem[i] = 16'h0000;
         m_mem[i] = 16'h0000;
         imem[i] = NOP;
      end
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      test_reset();
      test_lbi();
      test_arith();
      test_mem();
      test_branch();
      test_halt();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/proc_hier_core.md
Name: proc_hier_core

Overview:
- Single-cycle 16-bit processor core with an 8x16 register file and a reduced WISC-style ISA.
- Fetches from an external combinational instruction memory and accesses an external combinational data memory.
- Exposes per-cycle retirement signals (PC, instruction, register write, memory access, halt) that the system-level trace/log logic samples on every rising clock edge.
- Sits directly under the system top, beside the clock/reset generator.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  16  instruction fetch address (= pc)
- imem_data  in  16  instruction word at imem_addr, combinational
- dmem_rdata  in  16  data memory read word at mem_address, combinational
- pc  out  16  PC of the instruction executing this cycle
- inst  out  16  instruction executing this cycle
- reg_write  out  1  register file written at end of this cycle
- write_register  out  3  destination register index
- write_data  out  16  value written to the register file
- mem_read  out  1  data memory read this cycle
- mem_write  out  1  data memory write at end of this cycle
- mem_address  out  16  ALU result used as data address
- mem_data  out  16  store data (second source register)
- halt  out  1  HALT executing, or core halted
- cycle_count  out  32  cycles since reset released

Behaviour:
- ISA: opcode = inst[15:11].
  - 00000 HALT
  - 00001 NOP
  - 01000 ADDI: Rd=inst[7:5], Rs=inst[10:8]; Rd = Rs + sext(inst[4:0])
  - 10000 ST: mem[Rs + sext(inst[4:0])] = Rd, where Rd field is inst[7:5]
  - 10001 LD: Rd = mem[Rs + sext(inst[4:0])]
  - 11000 LBI: R[inst[10:8]] = sext(inst[7:0])
  - 11011 R-type: Rd=inst[4:2], Rs=inst[10:8], Rt=inst[7:5]; func inst[1:0]: 00 ADD, 01 SUB (Rt-Rs), 10 XOR, 11 AND
  - 01100 BEQZ: if R[inst[10:8]]==0, pc = pc+2+sext(inst[7:0])
  - 01101 BNEZ: as BEQZ, taken when R[inst[10:8]]!=0
  - 00100 J: pc = pc+2+sext(inst[10:0])
  - Undefined opcodes execute as NOP.
- All arithmetic is 16-bit modulo 2^16; no flags.
- Sequential PC = pc+2 (byte addressed).
- Register file: 8x16. Two combinational reads. One write on the rising edge when reg_write=1. R0 is a normal register. Write-then-read takes effect next cycle.
- Reset (rst=1 at posedge): pc=RESET_PC, all registers=0, halted flag=0, cycle_count=0. While rst is high, reg_write, mem_read, mem_write and halt = 0, and no state changes.
- HALT: halt=1 combinationally in the cycle HALT is fetched. On that edge a sticky halted flag sets and pc freezes. While halted: halt=1, reg_write=mem_write=mem_read=0, cycle_count keeps counting. Only rst clears halted.
- Output definitions:
  - mem_address = Rs + sext(imm5) for LD/ST, else ALU result.
  - mem_data = R[inst[7:5]] always.
  - write_data = dmem_rdata for LD, else ALU/immediate result.
  - pc = imem_addr; inst = imem_data.
- cycle_count increments by 1 every non-reset cycle and wraps at 2^32.
- Exactly one instruction retires per non-halted cycle.

Optional Feature:
- PROC_CYCLE_COUNT_EN
  - Defined: cycle_count behaves as above.
  - Undefined: cycle_count is tied to 0 and the counter register is not built.
  - All other behaviour is identical in both cases.

Test Plan:
- Reset then LBI R1,#0x85 -> reg_write=1, write_register=1, write_data=16'hFF85, pc=0x0000; next cycle pc=0x0002.
- LBI R1,5; LBI R2,3; ADD R3,R1,R2; SUB R4,R2,R1 -> R3=0x0008, R4=0xFFFE (3-5).
- LBI R1,0x10; ST R2,R1,#2 (R2=0x1234); LD R5,R1,#2 -> store: mem_write=1, mem_address=0x0012, mem_data=0x1234; load: mem_read=1, reg_write=1, write_data=0x1234.
- R1=0: BEQZ R1,#4 at pc 0x0008 -> next pc=0x000E. BNEZ R1,#4 -> next pc=0x000A. J #-2 at 0x0020 -> next pc=0x0020.
- HALT at pc 0x0006 -> halt=1 that cycle; pc stays 0x0006 and no writes for 10 cycles. Assert rst -> pc=0x0000, halt=0, cycle_count=0.
- 0x00FF wraps: ADDI R1,R1,#1 with R1=0xFFFF -> write_data=0x0000. cycle_count equals cycles since reset deassertion (with PROC_CYCLE_COUNT_EN), else 0.
